game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): BIRD_W, 16, bird sprite width in px.
REQ-002 SHALL have parameter BIRD_H, 16, bird sprite height in px.
REQ-003 SHALL have parameter PIPE_W, 40, pipe width in px.
REQ-004 SHALL have parameter GAP_H, 120, vertical gap height in px.
REQ-005 SHALL have parameter FLOOR_Y, 480, floor line in px.
REQ-006 SHALL have parameter DEATH_FRAMES, 60, length of the dying pause in frames.
REQ-007 SHALL have port clk, in, 1, single system clock; all logic on its rising edge.
REQ-008 SHALL have port reset, in, 1, synchronous, active-high.
REQ-009 SHALL have port frame_tick, in, 1, one-cycle pulse per video frame.
REQ-010 SHALL have port start, in, 1, level switch input.
REQ-011 SHALL have port flap, in, 1, one-cycle pulse from the keyboard decoder.
REQ-012 SHALL have ports bird_x and bird_y, in, 10 each, bird top-left position.
REQ-013 SHALL have ports pipe1_x..pipe3_x and pipe1_y..pipe3_y, in, 10 each; pipeN_y is the gap top edge.
REQ-014 SHALL have port master, out, 1, run-enable to the mover and score blocks.
REQ-015 SHALL have port game_reset, out, 1, one-cycle restart pulse to the mover and score blocks.
REQ-016 SHALL have port state, out, 2, FSM state.
REQ-017 SHALL have port pass_pulse, out, 1, one-cycle pulse per pipe cleared.
REQ-018 SHALL have port pipes_passed, out, 10, count of pipes cleared.

Function
REQ-019 SHALL implement the FSM states IDLE=0, PLAYING=1, DYING=2 and OVER=3.
REQ-020 SHALL evaluate inputs only on cycles with frame_tick=1; decisions register on that edge, giving 1-cycle latency.
REQ-021 SHALL, in IDLE, hold master=0 and, on a rising edge of start or on flap, pulse game_reset for 1 cycle and enter PLAYING.
REQ-022 SHALL, in PLAYING, hold master=1 and enter DYING when a hit is detected, loading the death counter with DEATH_FRAMES-1.
REQ-023 SHALL, in DYING, hold master=0, decrement the counter on each frame_tick, and enter OVER on a frame_tick when the counter equals 0.
REQ-024 SHALL, in OVER, hold master=0, ignore start, and on flap pulse game_reset and enter IDLE.
REQ-025 SHALL detect a pipe hit when bird_x+BIRD_W > pipe_x AND bird_x < pipe_x+PIPE_W AND (bird_y < pipe_y OR bird_y+BIRD_H > pipe_y+GAP_H).
REQ-026 SHALL detect a floor hit when bird_y+BIRD_H >= FLOOR_Y; bird_y=0 alone is not a hit.
REQ-027 SHALL compute all sums at 11 bits so that no comparison wraps.
REQ-028 SHALL keep a per-pipe passed flag: set when pipe_x+PIPE_W <= bird_x, cleared when pipe_x > bird_x (pipe respawned).
REQ-029 SHALL assert pass_pulse for exactly 1 cycle when a passed flag sets in PLAYING, and increment pipes_passed, saturating at 999.
REQ-030 SHALL make a hit win over a pass when both occur on the same frame_tick: no pass_pulse and no increment.
REQ-031 SHALL count at most one pass per pipe per frame; two pipes passing on the same tick add 2.
REQ-032 SHALL, when start rises and flap arrives in the same cycle, produce exactly one game_reset.
REQ-033 SHALL clear pipes_passed and all passed flags on game_reset.

Reset
REQ-034 SHALL, on reset=1 at any clock edge, set state=IDLE, master=0, game_reset=0, pass_pulse=0, pipes_passed=0, death counter 0, passed flags 0, and the start edge register 0.
REQ-035 SHALL abort a reset asserted mid-DYING or mid-PLAYING immediately, with no pulses in the following cycle.

Structure
REQ-036 SHALL place the state encoding and geometry defaults in the shared game constants package, which is also used by the mover and pixel_gen blocks.
REQ-037 SHALL instantiate the single sub-module collision_check three times, once per pipe; it is combinational and outputs hit and cleared.

Verification
REQ-038 SHALL verify reset then start rising: game_reset high for exactly 1 cycle, then state=1 and master=1.
REQ-039 SHALL verify bird (100,200) against pipe1 (90,250): on the next frame_tick, state goes 1->2 and master=0; after 60 further ticks, state=3.
REQ-040 SHALL verify bird (100,260) in pipe1's gap (pipe 90,250): no hit; when pipe1_x=60, one pass_pulse and pipes_passed=1, with no further pulse until pipe1_x>100.
REQ-041 SHALL verify bird_y=464 (16+464=480): floor hit on the next tick; bird_y=463 produces no hit.
REQ-042 SHALL verify a hit and a pass on the same tick: pipes_passed unchanged and state=2.
REQ-043 SHALL verify pipes_passed preset near 999 with two passes: it holds at 999; flap in OVER gives game_reset, state=0 and pipes_passed=0.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared game constants: FSM state encoding, default sprite/playfield geometry
// and the saturating score helper used by the game controller.
package game_ctrl_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PLAYING = 2'd1;
    localparam logic [1:0] ST_DYING   = 2'd2;
    localparam logic [1:0] ST_OVER    = 2'd3;

    localparam int BIRD_W_DEF       = 16;
    localparam int BIRD_H_DEF       = 16;
    localparam int PIPE_W_DEF       = 40;
    localparam int GAP_H_DEF        = 120;
    localparam int FLOOR_Y_DEF      = 480;
    localparam int DEATH_FRAMES_DEF = 60;

    localparam int POS_W     = 10;
    localparam int SUM_W     = 11;
    localparam int CNT_W     = 10;
    localparam int CNT_MAX   = 999;
    localparam int NUM_PIPES = 3;

    // Adds up to three passes in one frame and clamps at the display limit.
    function automatic logic [CNT_W-1:0] sat_add_count(input logic [CNT_W-1:0] cnt,
                                                       input logic [1:0]       inc);
        logic [CNT_W:0]   sum;
        logic [CNT_W-1:0] res;
        sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
        if (sum > (CNT_W+1)'(CNT_MAX)) begin
            res = CNT_W'(CNT_MAX);
        end else begin
            res = sum[CNT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/game_ctrl_collision_check.sv
// Combinational bird-versus-one-pipe geometry: overlap with the solid pipe
// body (hit) and bird fully right of the pipe (cleared).
module collision_check
    import game_ctrl_pkg::*;
#(
    parameter int BIRD_W = BIRD_W_DEF,
    parameter int BIRD_H = BIRD_H_DEF,
    parameter int PIPE_W = PIPE_W_DEF,
    parameter int GAP_H  = GAP_H_DEF
) (
    input  logic [POS_W-1:0] bird_x,
    input  logic [POS_W-1:0] bird_y,
    input  logic [POS_W-1:0] pipe_x,
    input  logic [POS_W-1:0] pipe_y,
    output logic             hit,
    output logic             cleared
);

    // One extra bit on every edge so right/bottom sums never wrap.
    logic [SUM_W-1:0] bird_l;
    logic [SUM_W-1:0] bird_t;
    logic [SUM_W-1:0] bird_r;
    logic [SUM_W-1:0] bird_b;
    logic [SUM_W-1:0] pipe_l;
    logic [SUM_W-1:0] pipe_r;
    logic [SUM_W-1:0] gap_t;
    logic [SUM_W-1:0] gap_b;
    logic             x_overlap;
    logic             outside_gap;

    assign bird_l = {1'b0, bird_x};
    assign bird_t = {1'b0, bird_y};
    assign bird_r = bird_l + SUM_W'(BIRD_W);
    assign bird_b = bird_t + SUM_W'(BIRD_H);
    assign pipe_l = {1'b0, pipe_x};
    assign pipe_r = pipe_l + SUM_W'(PIPE_W);
    assign gap_t  = {1'b0, pipe_y};
    assign gap_b  = gap_t + SUM_W'(GAP_H);

    assign x_overlap   = (bird_r > pipe_l) && (bird_l < pipe_r);
    assign outside_gap = (bird_t < gap_t) || (bird_b > gap_b);

    assign hit     = x_overlap && outside_gap;
    assign cleared = (pipe_r <= bird_l);

endmodule

// File: rtl/game_ctrl.sv
// Game supervisor: start/flap handling, collision-driven death pause,
// pipe-pass scoring. All decisions are taken on frame_tick cycles.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int BIRD_W       = BIRD_W_DEF,
    parameter int BIRD_H       = BIRD_H_DEF,
    parameter int PIPE_W       = PIPE_W_DEF,
    parameter int GAP_H        = GAP_H_DEF,
    parameter int FLOOR_Y      = FLOOR_Y_DEF,
    parameter int DEATH_FRAMES = DEATH_FRAMES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             start,
    input  logic             flap,
    input  logic [POS_W-1:0] bird_x,
    input  logic [POS_W-1:0] bird_y,
    input  logic [POS_W-1:0] pipe1_x,
    input  logic [POS_W-1:0] pipe2_x,
    input  logic [POS_W-1:0] pipe3_x,
    input  logic [POS_W-1:0] pipe1_y,
    input  logic [POS_W-1:0] pipe2_y,
    input  logic [POS_W-1:0] pipe3_y,
    output logic             master,
    output logic             game_reset,
    output logic [1:0]       state,
    output logic             pass_pulse,
    output logic [CNT_W-1:0] pipes_passed
);

    localparam int DCNT_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

    logic [1:0]           state_q,        state_d;
    logic [DCNT_W-1:0]    death_cnt_q,    death_cnt_d;
    logic                 start_prev_q,   start_prev_d;
    logic                 game_reset_q,   game_reset_d;
    logic                 pass_pulse_q,   pass_pulse_d;
    logic [CNT_W-1:0]     pipes_passed_q, pipes_passed_d;
    logic [NUM_PIPES-1:0] passed_q,       passed_d;

    logic [POS_W-1:0]     pipe_x [NUM_PIPES];
    logic [POS_W-1:0]     pipe_y [NUM_PIPES];
    logic [NUM_PIPES-1:0] pipe_hit;
    logic [NUM_PIPES-1:0] pipe_cleared;
    logic [NUM_PIPES-1:0] pipe_respawn;
    logic [NUM_PIPES-1:0] pass_new;
    logic [1:0]           pass_cnt;
    logic                 floor_hit;
    logic                 any_hit;
    logic                 start_rise;

    assign pipe_x[0] = pipe1_x;
    assign pipe_x[1] = pipe2_x;
    assign pipe_x[2] = pipe3_x;
    assign pipe_y[0] = pipe1_y;
    assign pipe_y[1] = pipe2_y;
    assign pipe_y[2] = pipe3_y;

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pipe
        collision_check #(
            .BIRD_W (BIRD_W),
            .BIRD_H (BIRD_H),
            .PIPE_W (PIPE_W),
            .GAP_H  (GAP_H)
        ) u_collision_check (
            .bird_x  (bird_x),
            .bird_y  (bird_y),
            .pipe_x  (pipe_x[g]),
            .pipe_y  (pipe_y[g]),
            .hit     (pipe_hit[g]),
            .cleared (pipe_cleared[g])
        );
        // A pipe reappearing to the right of the bird re-arms its pass flag.
        assign pipe_respawn[g] = (pipe_x[g] > bird_x);
    end

    assign floor_hit  = (({1'b0, bird_y} + SUM_W'(BIRD_H)) >= SUM_W'(FLOOR_Y));
    assign any_hit    = floor_hit || (|pipe_hit);
    assign start_rise = start && !start_prev_q;
    assign pass_new   = pipe_cleared & ~passed_q;

    always_comb begin
        pass_cnt = 2'd0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            pass_cnt = pass_cnt + {1'b0, pass_new[i]};
        end
    end

    always_comb begin
        state_d        = state_q;
        death_cnt_d    = death_cnt_q;
        start_prev_d   = start_prev_q;
        game_reset_d   = 1'b0;
        pass_pulse_d   = 1'b0;
        pipes_passed_d = pipes_passed_q;
        passed_d       = passed_q;

        if (frame_tick) begin
            start_prev_d = start;

            for (int i = 0; i < NUM_PIPES; i++) begin
                if (pipe_cleared[i]) begin
                    passed_d[i] = 1'b1;
                end else if (pipe_respawn[i]) begin
                    passed_d[i] = 1'b0;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    // Start edge and flap together still give a single restart.
                    if (start_rise || flap) begin
                        state_d      = ST_PLAYING;
                        game_reset_d = 1'b1;
                    end
                end
                ST_PLAYING: begin
                    // A collision on the same frame as a pass forfeits the pass.
                    if (any_hit) begin
                        state_d     = ST_DYING;
                        death_cnt_d = DCNT_W'(DEATH_FRAMES - 1);
                    end else if (pass_cnt != 2'd0) begin
                        pass_pulse_d   = 1'b1;
                        pipes_passed_d = sat_add_count(pipes_passed_q, pass_cnt);
                    end
                end
                ST_DYING: begin
                    if (death_cnt_q == '0) begin
                        state_d = ST_OVER;
                    end else begin
                        death_cnt_d = death_cnt_q - DCNT_W'(1);
                    end
                end
                ST_OVER: begin
                    if (flap) begin
                        state_d      = ST_IDLE;
                        game_reset_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (game_reset_d) begin
                pipes_passed_d = '0;
                passed_d       = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            death_cnt_q    <= '0;
            start_prev_q   <= 1'b0;
            game_reset_q   <= 1'b0;
            pass_pulse_q   <= 1'b0;
            pipes_passed_q <= '0;
            passed_q       <= '0;
        end else begin
            state_q        <= state_d;
            death_cnt_q    <= death_cnt_d;
            start_prev_q   <= start_prev_d;
            game_reset_q   <= game_reset_d;
            pass_pulse_q   <= pass_pulse_d;
            pipes_passed_q <= pipes_passed_d;
            passed_q       <= passed_d;
        end
    end

    assign master       = (state_q == ST_PLAYING);
    assign game_reset   = game_reset_q;
    assign state        = state_q;
    assign pass_pulse   = pass_pulse_q;
    assign pipes_passed = pipes_passed_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: each tick/reset queues its expected outputs,
// a monitor compares them on the following falling edge.
module tb_game_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       flap = 1'b0;
    logic [9:0] bird_x, bird_y;
    logic [9:0] p1x, p2x, p3x, p1y, p2y, p3y;
    logic       master, game_reset, pass_pulse;
    logic [1:0] state;
    logic [9:0] pipes_passed;

    always #5 clk = ~clk;

    game_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .start        (start),
        .flap         (flap),
        .bird_x       (bird_x),
        .bird_y       (bird_y),
        .pipe1_x      (p1x),
        .pipe2_x      (p2x),
        .pipe3_x      (p3x),
        .pipe1_y      (p1y),
        .pipe2_y      (p2y),
        .pipe3_y      (p3y),
        .master       (master),
        .game_reset   (game_reset),
        .state        (state),
        .pass_pulse   (pass_pulse),
        .pipes_passed (pipes_passed)
    );

    typedef struct packed {
        logic [1:0] st;
        logic       gr;
        logic       pp;
        logic [9:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;
    logic chk_seen = 1'b0;
    logic armed = 1'b0;

    always @(posedge clk) begin
        chk_seen <= frame_tick | reset;
        if (reset) armed <= 1'b1;
    end

    // Monitor: checked cycles pop the scoreboard; all other cycles must be pulse-free.
    always @(negedge clk) begin
        if (chk_seen) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL check%0d: DUT cycle with no queued expectation (state=%0d)", n_checks, state);
            end else begin
                e = exp_q.pop_front();
                if (state !== e.st || master !== (e.st == 2'd1) || game_reset !== e.gr ||
                    pass_pulse !== e.pp || pipes_passed !== e.cnt) begin
                    n_fail++;
                    $display("FAIL check%0d: got state=%0d master=%0d game_reset=%0d pass_pulse=%0d pipes_passed=%0d, expected state=%0d master=%0d game_reset=%0d pass_pulse=%0d pipes_passed=%0d",
                             n_checks, state, master, game_reset, pass_pulse, pipes_passed,
                             e.st, (e.st == 2'd1), e.gr, e.pp, e.cnt);
                end
            end
        end else if (armed) begin
            n_checks++;
            if (game_reset !== 1'b0 || pass_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL pulse_width%0d: got game_reset=%0d pass_pulse=%0d, expected both 0",
                         n_checks, game_reset, pass_pulse);
            end
        end
    end

    task automatic step(input logic [1:0] st, input logic gr, input logic pp,
                        input logic [9:0] cnt, input logic fl);
        @(negedge clk);
        frame_tick = 1'b1;
        flap = fl;
        exp_q.push_back(exp_t'{st: st, gr: gr, pp: pp, cnt: cnt});
        @(negedge clk);
        frame_tick = 1'b0;
        flap = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b1;
            exp_q.push_back(exp_t'{st: 2'd0, gr: 1'b0, pp: 1'b0, cnt: 10'd0});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        bird_x = 10'd100; bird_y = 10'd260;
        p1x = 10'd500; p2x = 10'd500; p3x = 10'd500;
        p1y = 10'd250; p2y = 10'd250; p3y = 10'd250;

        // Game A: start edge, gap flight, passes, floor boundary, pipe hit, death pause
        do_reset(2);
        step(2'd0, 1'b0, 1'b0, 10'd0, 1'b0);
        start = 1'b1;
        step(2'd1, 1'b1, 1'b0, 10'd0, 1'b0);
        step(2'd1, 1'b0, 1'b0, 10'd0, 1'b0);
        p1x = 10'd90;
        step(2'd1, 1'b0, 1'b0, 10'd0, 1'b0);
        p1x = 10'd60;
        step(2'd1, 1'b0, 1'b1, 10'd1, 1'b0);
        step(2'd1, 1'b0, 1'b0, 10'd1, 1'b0);
        p1x = 10'd100;
        step(2'd1, 1'b0, 1'b0, 10'd1, 1'b0);
        p1x = 10'd101;
        step(2'd1, 1'b0, 1'b0, 10'd1, 1'b0);
        p1x = 10'd60;
        step(2'd1, 1'b0, 1'b1, 10'd2, 1'b0);
        p1x = 10'd500; bird_y = 10'd463;
        step(2'd1, 1'b0, 1'b0, 10'd2, 1'b0);
        bird_y = 10'd0;
        step(2'd1, 1'b0, 1'b0, 10'd2, 1'b0);
        bird_y = 10'd200; p1x = 10'd90;
        step(2'd2, 1'b0, 1'b0, 10'd2, 1'b0);
        for (int i = 0; i < 59; i++) step(2'd2, 1'b0, 1'b0, 10'd2, 1'b0);
        step(2'd3, 1'b0, 1'b0, 10'd2, 1'b0);
        p1x = 10'd500;
        start = 1'b0;
        step(2'd3, 1'b0, 1'b0, 10'd2, 1'b0);
        start = 1'b1;
        step(2'd3, 1'b0, 1'b0, 10'd2, 1'b0);
        step(2'd0, 1'b1, 1'b0, 10'd0, 1'b1);

        // Game B: start edge with flap together, hit beats pass, reset mid-dying
        start = 1'b0;
        step(2'd0, 1'b0, 1'b0, 10'd0, 1'b0);
        start = 1'b1;
        step(2'd1, 1'b1, 1'b0, 10'd0, 1'b1);
        step(2'd1, 1'b0, 1'b0, 10'd0, 1'b0);
        bird_y = 10'd260; p1x = 10'd40;
        step(2'd1, 1'b0, 1'b1, 10'd1, 1'b0);
        p1x = 10'd200;
        step(2'd1, 1'b0, 1'b0, 10'd1, 1'b0);
        p1x = 10'd40; p2x = 10'd90; p2y = 10'd300;
        step(2'd2, 1'b0, 1'b0, 10'd1, 1'b0);
        step(2'd2, 1'b0, 1'b0, 10'd1, 1'b0);
        step(2'd2, 1'b0, 1'b0, 10'd1, 1'b0);
        do_reset(1);

        // Game C: score saturation at 999, floor death, restart clears score
        p1x = 10'd500; p2x = 10'd500; p2y = 10'd250; start = 1'b0;
        step(2'd0, 1'b0, 1'b0, 10'd0, 1'b0);
        start = 1'b1;
        step(2'd1, 1'b1, 1'b0, 10'd0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 332; i++) begin
            p1x = 10'd40; p2x = 10'd40; p3x = 10'd40;
            cnt += 3;
            step(2'd1, 1'b0, 1'b1, 10'(cnt), 1'b0);
            p1x = 10'd200; p2x = 10'd200; p3x = 10'd200;
            step(2'd1, 1'b0, 1'b0, 10'(cnt), 1'b0);
        end
        p1x = 10'd40; p2x = 10'd40;
        step(2'd1, 1'b0, 1'b1, 10'd998, 1'b0);
        p1x = 10'd200; p2x = 10'd200;
        step(2'd1, 1'b0, 1'b0, 10'd998, 1'b0);
        p1x = 10'd40; p2x = 10'd40;
        step(2'd1, 1'b0, 1'b1, 10'd999, 1'b0);
        p1x = 10'd200; p2x = 10'd200;
        step(2'd1, 1'b0, 1'b0, 10'd999, 1'b0);
        p1x = 10'd40;
        step(2'd1, 1'b0, 1'b1, 10'd999, 1'b0);
        bird_y = 10'd464;
        step(2'd2, 1'b0, 1'b0, 10'd999, 1'b0);
        for (int i = 0; i < 59; i++) step(2'd2, 1'b0, 1'b0, 10'd999, 1'b0);
        step(2'd3, 1'b0, 1'b0, 10'd999, 1'b0);
        step(2'd0, 1'b1, 1'b0, 10'd0, 1'b1);
        step(2'd0, 1'b0, 1'b0, 10'd0, 1'b0);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
